// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, ALU/branch encodings, memory FSM states and the decode record
// for the multi-cycle CPU control unit.
package cpu_ctrl_pkg;

  localparam logic [7:0] OP_ADD   = 8'h00;
  localparam logic [7:0] OP_SUB   = 8'h01;
  localparam logic [7:0] OP_AND   = 8'h02;
  localparam logic [7:0] OP_OR    = 8'h03;
  localparam logic [7:0] OP_MOV   = 8'h04;
  localparam logic [7:0] OP_LOADI = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;
  localparam logic [7:0] OP_MULT  = 8'h09;
  localparam logic [7:0] OP_SL    = 8'h0A;
  localparam logic [7:0] OP_SRA   = 8'h0C;
  localparam logic [7:0] OP_ROR   = 8'h0D;
  localparam logic [7:0] OP_LWD   = 8'h0E;
  localparam logic [7:0] OP_LWI   = 8'h0F;
  localparam logic [7:0] OP_SWD   = 8'h10;
  localparam logic [7:0] OP_SWI   = 8'h11;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_ROR = 3'b111;

  localparam logic [1:0] BR_SEQ  = 2'b00;
  localparam logic [1:0] BR_JUMP = 2'b01;
  localparam logic [1:0] BR_BEQ  = 2'b10;
  localparam logic [1:0] BR_BNE  = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} mem_state_e;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc;
    logic       nemux;
    logic [1:0] branch;
    logic       wen;
    logic       is_mem;
    logic       is_load;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder; everything is zero unless INSTR_VALID is high.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 8
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  output dec_t                dec
);

  always_comb begin
    dec = '0;
    if (instr_valid) begin
      case (opcode)
        OPCODE_W'(OP_ADD):   begin dec.aluop = ALU_ADD; dec.alusrc = 1'b1; dec.wen = 1'b1; end
        OPCODE_W'(OP_SUB):   begin dec.aluop = ALU_ADD; dec.alusrc = 1'b1; dec.nemux = 1'b1; dec.wen = 1'b1; end
        OPCODE_W'(OP_AND):   begin dec.aluop = ALU_AND; dec.alusrc = 1'b1; dec.wen = 1'b1; end
        OPCODE_W'(OP_OR):    begin dec.aluop = ALU_OR;  dec.alusrc = 1'b1; dec.wen = 1'b1; end
        OPCODE_W'(OP_MOV):   begin dec.aluop = ALU_FWD; dec.alusrc = 1'b1; dec.wen = 1'b1; end
        OPCODE_W'(OP_LOADI): begin dec.aluop = ALU_FWD; dec.wen = 1'b1; end
        OPCODE_W'(OP_J):     begin dec.branch = BR_JUMP; end
        // Branch compares subtract the operands, so they need the negated path.
        OPCODE_W'(OP_BEQ):   begin dec.aluop = ALU_ADD; dec.alusrc = 1'b1; dec.nemux = 1'b1; dec.branch = BR_BEQ; end
        OPCODE_W'(OP_BNE):   begin dec.aluop = ALU_ADD; dec.alusrc = 1'b1; dec.nemux = 1'b1; dec.branch = BR_BNE; end
        OPCODE_W'(OP_MULT):  begin dec.aluop = ALU_MUL; dec.alusrc = 1'b1; dec.wen = 1'b1; end
        OPCODE_W'(OP_SL):    begin dec.aluop = ALU_SLL; dec.wen = 1'b1; end
        OPCODE_W'(OP_SRA):   begin dec.aluop = ALU_SRA; dec.wen = 1'b1; end
        OPCODE_W'(OP_ROR):   begin dec.aluop = ALU_ROR; dec.wen = 1'b1; end
        OPCODE_W'(OP_LWD):   begin dec.alusrc = 1'b1; dec.is_mem = 1'b1; dec.is_load = 1'b1; end
        OPCODE_W'(OP_LWI):   begin dec.is_mem = 1'b1; dec.is_load = 1'b1; end
        OPCODE_W'(OP_SWD):   begin dec.alusrc = 1'b1; dec.is_mem = 1'b1; end
        OPCODE_W'(OP_SWI):   begin dec.is_mem = 1'b1; end
        default:             dec.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: combinational ALU/branch decode plus a registered
// memory-access FSM that stalls the PC, gates load write-back and traps timeouts.
module control_unit_mc
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W       = 8,
  parameter int ALUOP_W        = 3,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                INSTR_VALID,
  input  logic                BUSYWAIT,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic                ALUSRC,
  output logic                NEMUX,
  output logic [1:0]          BRANCH,
  output logic                WRITEENABLE,
  output logic                WRITESRC,
  output logic                READ,
  output logic                WRITE,
  output logic                HOLD,
  output logic                ILLEGAL_OP,
  output logic                MEM_FAULT
);

  dec_t dec;

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_load_q, is_load_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic             fault_q, fault_d;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode      (OPCODE),
    .instr_valid (INSTR_VALID),
    .dec         (dec)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    read_d    = read_q;
    write_d   = write_q;
    fault_d   = fault_q;
    case (state_q)
      IDLE: begin
        if (dec.is_mem) begin
          state_d   = ACCESS;
          is_load_d = dec.is_load;
          read_d    = dec.is_load;
          write_d   = !dec.is_load;
          cnt_d     = '0;
        end
      end
      ACCESS: begin
        if (!BUSYWAIT) begin
          state_d = DONE;
          read_d  = 1'b0;
          write_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = FAULT;
          read_d  = 1'b0;
          write_d = 1'b0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: ; // FAULT is terminal until reset
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
      read_q    <= read_d;
      write_q   <= write_d;
      fault_q   <= fault_d;
    end
  end

  assign ALUOP      = ALUOP_W'(dec.aluop);
  assign ALUSRC     = dec.alusrc;
  assign NEMUX      = dec.nemux;
  assign BRANCH     = dec.branch;
  assign ILLEGAL_OP = dec.illegal;
  assign READ       = read_q;
  assign WRITE      = write_q;
  assign MEM_FAULT  = fault_q;
  // In DONE the opcode may already be the next instruction, so use the latched kind.
  assign WRITESRC   = (state_q == DONE) ? is_load_q : dec.is_load;

  always_comb begin
    WRITEENABLE = 1'b0;
    HOLD        = 1'b1;
    case (state_q)
      IDLE: begin
        WRITEENABLE = dec.wen;
        HOLD        = dec.is_mem;
      end
      DONE: begin
        WRITEENABLE = is_load_q;
        HOLD        = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_unit_mc.md
Name: control_unit_mc

Overview:
Multi-cycle successor to the single-cycle CPU control unit. It decodes the 8-bit opcode combinationally for ALU and branch controls, and runs a registered memory-access FSM. The FSM issues READ/WRITE, stalls the PC via HOLD while BUSYWAIT is high, gates load write-back, and traps memory accesses that never complete. It sits between instruction fetch/PC logic, the register file/ALU datapath, and the data memory or cache.

Parameters:
OPCODE_W, 8, opcode width; opcodes are zero-extended for comparison.
ALUOP_W, 3, ALU operation selector width.
TIMEOUT_CYCLES, 64, maximum ACCESS cycles with BUSYWAIT=1 before FAULT; legal range is 2 or more.
CNT_W, $clog2(TIMEOUT_CYCLES+1), wait-counter width.

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
RESET  in  1  asynchronous, active-low reset.
OPCODE  in  OPCODE_W  opcode of the current instruction.
INSTR_VALID  in  1  OPCODE is valid this cycle.
BUSYWAIT  in  1  data memory busy.
ALUOP  out  ALUOP_W  ALU operation: 000 fwd, 001 add, 010 and, 011 or, 100 mul, 101 sll, 110 sra, 111 ror.
ALUSRC  out  1  1 selects the register operand, 0 selects the immediate.
NEMUX  out  1  1 selects the two's-complement operand.
BRANCH  out  2  00 sequential, 01 jump, 10 beq, 11 bne.
WRITEENABLE  out  1  register-file write enable.
WRITESRC  out  1  write-back source: 0 ALU result, 1 memory read data.
READ  out  1  memory read request (registered).
WRITE  out  1  memory write request (registered).
HOLD  out  1  PC stall.
ILLEGAL_OP  out  1  opcode is not in the ISA.
MEM_FAULT  out  1  sticky memory timeout flag.

Behaviour:
- ISA: 00 add, 01 sub, 02 and, 03 or, 04 mov, 05 loadi, 06 j, 07 beq, 08 bne, 09 mult, 0A sl, 0C sra, 0D ror, 0E lwd, 0F lwi, 10 swd, 11 swi.
- Any other opcode, or INSTR_VALID=0, drives all enables/branch to 0 and ALUOP=000. ILLEGAL_OP=1 only for an undefined opcode with INSTR_VALID=1.
- ALUOP, ALUSRC, NEMUX, BRANCH and WRITESRC are combinational from OPCODE. No #delays.
- Memory ops: lwd/lwi (reg/imm address) are loads; swd/swi are stores. ALUOP=000 for all four.
- Non-memory ops: WRITEENABLE is combinational from the decode table, asserted only in IDLE. Branch and store ops have WRITEENABLE=0.
- FSM states and transitions:
  - IDLE: READ=WRITE=0. If INSTR_VALID and mem op: HOLD=1 combinationally; latch is_load at the edge; go to ACCESS. Otherwise HOLD=0.
  - ACCESS: READ=is_load, WRITE=!is_load, both registered and stable. HOLD=1. WRITEENABLE=0. Minimum 1 cycle.
    - At an edge with BUSYWAIT=0: go to DONE (zero-wait hit allowed).
    - At an edge with BUSYWAIT=1: counter++. If counter==TIMEOUT_CYCLES-1: go to FAULT.
  - DONE: one cycle. READ=WRITE=0, HOLD=0. WRITEENABLE=is_load, WRITESRC=is_load. The PC advances and the register write occurs at the end of DONE. Counter clears. Return to IDLE.
  - FAULT: READ=WRITE=0, HOLD=1, MEM_FAULT=1, WRITEENABLE=0. Remains until RESET.
- OPCODE changes while in ACCESS/DONE/FAULT are ignored for memory state; is_load is held.
- Reset (async, any state including mid-ACCESS): state=IDLE, counter=0, is_load=0, READ=WRITE=MEM_FAULT=0. HOLD then follows the IDLE rule.
- Back-to-back memory ops: after DONE→IDLE, a new mem op re-enters ACCESS one cycle later. There is no idle gap beyond that IDLE decode cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams;
  - ALUOP and BRANCH encodings;
  - FSM state enum {IDLE, ACCESS, DONE, FAULT};
  - a packed decode struct (aluop, alusrc, nemux, branch, wen, is_mem, is_load, illegal).
- Sub-module ctrl_decode is the combinational opcode→struct decoder. control_unit_mc instantiates it and adds the FSM, counter and output gating.

Test Plan:
1. Reset low mid-ACCESS (after 3 busy cycles) → READ=WRITE=0 and state IDLE immediately, asynchronously; MEM_FAULT=0.
2. Opcode 00 (add), VALID=1 → ALUOP=001, ALUSRC=1, NEMUX=0, WRITEENABLE=1, HOLD=0, READ=WRITE=0. Opcode 01 → NEMUX=1.
3. Opcode 0E, BUSYWAIT high for 4 edges then low:
   - HOLD=1 from the decode cycle;
   - READ=1 for 5 ACCESS cycles;
   - DONE cycle shows WRITEENABLE=1, WRITESRC=1, HOLD=0;
   - then IDLE.
4. Opcode 11, BUSYWAIT=0 throughout → one ACCESS cycle with WRITE=1, then DONE with WRITEENABLE=0; total stall is 2 cycles.
5. Opcode 0F with BUSYWAIT stuck at 1 and TIMEOUT_CYCLES=8 → FAULT entered after 8 ACCESS cycles; MEM_FAULT=1, HOLD=1, READ=0. Only reset clears it.
6. Opcode 0B, VALID=1 → ILLEGAL_OP=1, all enables 0, BRANCH=00, no FSM transition.
